// File: rtl/conv_window_3x3.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 window, valid (unpadded) windows only.
// Optional Last_Out frame-end flag is enabled by defining CONV_WINDOW_LAST_EN.
module conv_window_3x3 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDTH-1:0] Data_Out0,
    output logic [DATA_WIDTH-1:0] Data_Out1,
    output logic [DATA_WIDTH-1:0] Data_Out2,
    output logic [DATA_WIDTH-1:0] Data_Out3,
    output logic [DATA_WIDTH-1:0] Data_Out4,
    output logic [DATA_WIDTH-1:0] Data_Out5,
    output logic [DATA_WIDTH-1:0] Data_Out6,
    output logic [DATA_WIDTH-1:0] Data_Out7,
    output logic [DATA_WIDTH-1:0] Data_Out8,
`ifdef CONV_WINDOW_LAST_EN
    output logic                  Last_Out,
`endif
    output logic                  Valid_Out
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_win [9];
    logic [DATA_WIDTH-1:0] r_out [9];
    logic                  r_valid;

    logic [DATA_WIDTH-1:0] w_lb0;
    logic [DATA_WIDTH-1:0] w_lb1;
    logic [DATA_WIDTH-1:0] w_next [9];
    logic                  w_colLast;
    logic                  w_rowLast;
    logic                  w_winValid;

    assign w_lb0      = r_lb0[r_col];
    assign w_lb1      = r_lb1[r_col];
    assign w_colLast  = (r_col == CW'(IMG_WIDTH - 1));
    assign w_rowLast  = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_winValid = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // Window shifted left by one column, new right column is {lb1, lb0, Data_In}.
    always_comb begin
        w_next[0] = r_win[1];
        w_next[1] = r_win[2];
        w_next[2] = w_lb1;
        w_next[3] = r_win[4];
        w_next[4] = r_win[5];
        w_next[5] = w_lb0;
        w_next[6] = r_win[7];
        w_next[7] = r_win[8];
        w_next[8] = Data_In;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (Valid_In) begin
            if (w_colLast) begin
                r_col <= '0;
                r_row <= w_rowLast ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Plain RAM: reads above are combinational, so a same-address write sees the old value.
    always_ff @(posedge clk) begin
        if (Valid_In) begin
            r_lb1[r_col] <= w_lb0;
            r_lb0[r_col] <= Data_In;
        end
    end

    // Outputs only load on a complete window so they hold across masked pixels and gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
                r_out[i] <= '0;
            end
            r_valid <= 1'b0;
        end else begin
            r_valid <= Valid_In && w_winValid;
            if (Valid_In) begin
                for (int i = 0; i < 9; i++) begin
                    r_win[i] <= w_next[i];
                end
                if (w_winValid) begin
                    for (int i = 0; i < 9; i++) begin
                        r_out[i] <= w_next[i];
                    end
                end
            end
        end
    end

`ifdef CONV_WINDOW_LAST_EN
    logic r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b0;
        end else begin
            r_last <= Valid_In && w_winValid && w_colLast && w_rowLast;
        end
    end

    assign Last_Out = r_last;
`endif

    assign Data_Out0 = r_out[0];
    assign Data_Out1 = r_out[1];
    assign Data_Out2 = r_out[2];
    assign Data_Out3 = r_out[3];
    assign Data_Out4 = r_out[4];
    assign Data_Out5 = r_out[5];
    assign Data_Out6 = r_out[6];
    assign Data_Out7 = r_out[7];
    assign Data_Out8 = r_out[8];
    assign Valid_Out = r_valid;

endmodule

// File: doc/conv_window_3x3.md
# conv_window_3x3

- Streaming 3x3 sliding-window generator, upstream of the 3x3 convolution core.
- Accepts one FP32 pixel per valid cycle in row-major raster order.
- Buffers the two previous image rows and emits the nine pixels of each complete 3x3 window, with a valid strobe, ready to drive the core's nine data inputs directly.
- Uses valid ("no padding") convolution: a frame of W×H produces (W-2)·(H-2) windows.

## Interface
- DATA_WIDTH, 32: pixel word width (IEEE-754 single).
- IMG_WIDTH, 28: pixels per row; legal range ≥3.
- IMG_HEIGHT, 28: rows per frame; legal range ≥3.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- Data_In  in  DATA_WIDTH  pixel, accepted when Valid_In=1.
- Valid_In  in  1  pixel qualifier; no back-pressure exists.
- Data_Out0..Data_Out8  out  DATA_WIDTH each  window, row-major; 0 = top-left (oldest), 8 = bottom-right (newest pixel).
- Valid_Out  out  1  one-cycle strobe: Data_Out0..8 hold a new window.

## Operation
- State:
  - col counter, 0..IMG_WIDTH-1.
  - row counter, 0..IMG_HEIGHT-1.
  - Two line buffers of IMG_WIDTH words: lb0 holds the previous row, lb1 the row before it. They share one address, col.
  - 3x3 window register array.
- On an accepted pixel at (row r, col c):
  - Read lb1[c] and lb0[c].
  - Write lb1[c] ← lb0[c] and lb0[c] ← Data_In.
  - Shift the window left by one column. The new right column is {lb1[c], lb0[c], Data_In} (top to bottom).
- Window mapping: Data_Out0/1/2 = top row, Data_Out3/4/5 = middle row, Data_Out6/7/8 = bottom row. Left to right within each row is oldest to newest column.
- Valid window condition: r ≥ 2 and c ≥ 2, evaluated on the accepted pixel.
- Counter advance:
  - col increments on each accepted pixel.
  - At c = IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), row and col both wrap to 0 and the next frame begins.
- Stale data:
  - Line-buffer contents left over from a previous frame, or present after reset, are never emitted. The row/col condition masks them.
  - Window columns carried over from the previous row are masked by the c ≥ 2 condition.
- Valid_In=0: no state changes. Counters, buffers and window all hold.
- Line-buffer storage is not reset and may map to distributed or block RAM. A read-before-write on the same address in the same cycle must return the old value.

## Timing
- Reset values:
  - Valid_Out=0.
  - Data_Out0..8 = 0.
  - col = row = 0.
- Latency: the pixel completing a window is accepted at edge N. Data_Out and Valid_Out update at edge N, so they are visible during cycle N+1. Valid_Out is registered.
- Valid_Out is high for exactly one cycle per qualifying accepted pixel. Back-to-back windows give Valid_Out continuously high.
- If Valid_In is low for a cycle, Valid_Out is low the following cycle and Data_Out holds its last value.
- Valid_Out never asserts for pixels in rows 0–1 or columns 0–1.
- Throughput: one pixel per cycle, sustained indefinitely across frame boundaries with no bubble.
- Reset asserted mid-frame:
  - Immediate asynchronous clear of outputs and counters.
  - After release, the next accepted pixel is treated as (0,0) of a new frame.

## Configuration
- CONV_WINDOW_LAST_EN:
  - Defined: adds output Last_Out (1 bit, reset 0). It is registered with Valid_Out and is high only with the window completed by pixel (IMG_HEIGHT-1, IMG_WIDTH-1), the last window of the frame.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst=0 with Valid_In=1 and random data → Valid_Out=0 and all Data_Out=0 throughout. Release, then feed IMG_WIDTH=5, IMG_HEIGHT=4, pixels 0..19 in order → first Valid_Out comes the cycle after pixel 12, with Data_Out0..8 = 0,1,2,5,6,7,10,11,12.
- Window count: same 5×4 frame, continuous → exactly 6 strobes. Windows end at pixels 12,13,14,17,18,19. The last window is 12,13,14,17,18,19? No: the last window is 7,8,9,12,13,14,17,18,19.
- Gaps: same frame with Valid_In toggling 1,0 every cycle → identical 6 windows, each strobe one cycle wide. Data_Out holds between strobes.
- Frame wrap: two back-to-back 5×4 frames with frame 2 pixels = 100+index → no strobe for frame-2 pixels 0–11. First frame-2 window is 100,101,102,105,106,107,110,111,112.
- Mid-frame reset: pulse rst low after pixel 8, then restart the frame from 0 → output matches the clean-reset case exactly, with no stale window.
- CONV_WINDOW_LAST_EN defined: 5×4 frame → Last_Out high only with the window ending at pixel 19, coincident with Valid_Out.
